// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with one outstanding imem request and a
// small PC/instruction FIFO in front of the IF/ID register.
// Optional feature macro: FETCH_BYPASS_EN (forward a response straight to the
// IF/ID side when the queue is empty).
//
// state | meaning
// RUN   | may issue a request at fetch_pc when a queue slot is free
// WAIT  | request granted, waiting for its word; word is pushed on rvalid
// DROP  | a redirect made the outstanding request stale; its word is discarded

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [63:0] if_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP} state_t;

  state_t        state_q, state_d;
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   issued_pc_q, issued_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0]   buf_instr_q [DEPTH];
  logic [63:0]   buf_pc_q    [DEPTH];

  logic          fifo_valid;
  logic          bypass_hit;
  logic          grant;
  logic          push;
  logic          pop;

  assign fifo_valid = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = (count_q == '0) && (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
`else
  assign bypass_hit = 1'b0;
`endif

  // Request side: only RUN issues, and only when a slot is free for the reply.
  assign imem_req  = (state_q == S_RUN) && (count_q < DEPTH_C) && !reset;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  // Queue head toward IF/ID, zeroed when nothing is valid.
  always_comb begin
    if_valid       = fifo_valid || bypass_hit;
    if_instruction = 32'h0;
    if_pc          = 64'h0;
    if (fifo_valid) begin
      if_instruction = buf_instr_q[rd_ptr_q];
      if_pc          = buf_pc_q[rd_ptr_q];
    end else if (bypass_hit) begin
      if_instruction = imem_rdata;
      if_pc          = issued_pc_q;
    end
  end

  // Next-state, PC, pointer and occupancy logic; redirect overrides the rest.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    push        = 1'b0;
    pop         = fifo_valid && if_ready;

    case (state_q)
      S_RUN: begin
        if (grant) begin
          issued_pc_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + 64'd4;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // A bypassed word taken by IF/ID this cycle never enters the queue.
          push    = !(bypass_hit && if_ready);
          state_d = S_RUN;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      push       = 1'b0;
      pop        = 1'b0;
      case (state_q)
        S_RUN:   state_d = grant ? S_DROP : S_RUN;
        default: state_d = imem_rvalid ? S_RUN : S_DROP;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= 64'h0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Queue storage; contents are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= issued_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-programmable memory responder plus
// one task per scenario, each checking outputs against hand-derived values.

module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instruction;
  logic [63:0] if_pc;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instruction(if_instruction), .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    int          cyc;
  } ev_t;

  ev_t dlv[$];
  ev_t gnts[$];

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic        mem_pending = 1'b0;
  int          mem_delay = 0;
  logic [63:0] mem_addr_p = 64'h0;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return {8'h13, a[23:0]};
  endfunction

  // One clock: log grants/deliveries before the edge, then update the memory.
  task automatic cycle();
    logic        g;
    logic [63:0] ga;
    logic        rst_now;
    ev_t         e;
    #1;
    g       = (imem_req === 1'b1) && (imem_gnt === 1'b1);
    ga      = imem_addr;
    rst_now = reset;
    if (g && !reset) begin
      e.pc = ga; e.instr = 32'h0; e.cyc = cyc;
      gnts.push_back(e);
    end
    if ((if_valid === 1'b1) && if_ready && !redirect_valid && !reset) begin
      e.pc = if_pc; e.instr = if_instruction; e.cyc = cyc;
      dlv.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    if (rst_now) begin
      mem_pending = 1'b0;
    end else if (g) begin
      mem_pending = 1'b1;
      mem_delay   = mem_lat;
      mem_addr_p  = ga;
    end
    if (mem_pending) begin
      mem_delay--;
      if (mem_delay <= 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(mem_addr_p);
        mem_pending = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; imem_gnt = 1'b1; if_ready = 1'b1; mem_lat = 1;
    cycle();
    cycle();
    reset = 1'b0;
    cyc = 0;
    dlv.delete();
    gnts.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_gnt = 1'b1; if_ready = 1'b1;
    cycle();
    cycle();
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    tests_run++;
    if (imem_addr !== 64'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    tests_run++;
    if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
    tests_run++;
    if (if_instruction !== 32'h0 || if_pc !== 64'h0) begin
      tests_failed++; $display("FAIL reset_if_data: got instr %h pc %h expected 0 0", if_instruction, if_pc);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      tests_failed++; $display("FAIL first_req: got req %b addr %h expected 1 0", imem_req, imem_addr);
    end
    cyc = 0;
    dlv.delete();
    gnts.delete();
  endtask

  task automatic test_stream();
    repeat (8) cycle();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (gnts.size() <= i || gnts[i].pc !== 64'(4 * i) || gnts[i].cyc != 2 * i) begin
        tests_failed++;
        $display("FAIL stream_grant%0d: got n=%0d addr %h cyc %0d expected addr %h cyc %0d",
                 i, gnts.size(), gnts[i].pc, gnts[i].cyc, 64'(4 * i), 2 * i);
      end
      tests_run++;
      if (dlv.size() <= i || dlv[i].pc !== 64'(4 * i) || dlv[i].instr !== word_at(64'(4 * i))
          || dlv[i].cyc != 2 * i + LAT) begin
        tests_failed++;
        $display("FAIL stream_deliver%0d: got pc %h instr %h cyc %0d expected pc %h instr %h cyc %0d",
                 i, dlv[i].pc, dlv[i].instr, dlv[i].cyc, 64'(4 * i), word_at(64'(4 * i)), 2 * i + LAT);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    if_ready = 1'b0;
    repeat (20) cycle();
    tests_run++;
    if (gnts.size() != 4) begin tests_failed++; $display("FAIL stall_grants: got %0d expected 4", gnts.size()); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (gnts.size() <= i || gnts[i].pc !== 64'(4 * i)) begin
        tests_failed++; $display("FAIL stall_addr%0d: got %h expected %h", i, gnts[i].pc, 64'(4 * i));
      end
    end
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL stall_req_full: got %b expected 0", imem_req); end
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 64'h0) begin
      tests_failed++; $display("FAIL stall_head: got valid %b pc %h expected 1 0", if_valid, if_pc);
    end
    dlv.delete();
    if_ready = 1'b1;
    repeat (12) cycle();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (dlv.size() <= i || dlv[i].pc !== 64'(4 * i) || dlv[i].cyc != dlv[0].cyc + i) begin
        tests_failed++;
        $display("FAIL drain%0d: got pc %h cyc %0d expected pc %h cyc %0d",
                 i, dlv[i].pc, dlv[i].cyc, 64'(4 * i), dlv[0].cyc + i);
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    repeat (4) cycle();
    mem_lat = 3;
    cycle();
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rw_wait_req: got %b expected 0", imem_req); end
    redirect_valid = 1'b1; redirect_pc = 64'h100; mem_lat = 1;
    cycle();
    redirect_valid = 1'b0;
    tests_run++;
    if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rw_valid_after: got %b expected 0", if_valid); end
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rw_drop_req: got %b expected 0", imem_req); end
    dlv.delete();
    repeat (6) cycle();
    tests_run++;
    if (dlv.size() == 0 || dlv[0].pc !== 64'h100 || dlv[0].instr !== word_at(64'h100)) begin
      tests_failed++;
      $display("FAIL rw_next_pc: got n=%0d pc %h instr %h expected pc 100 instr %h",
               dlv.size(), dlv[0].pc, dlv[0].instr, word_at(64'h100));
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    cycle();
    redirect_valid = 1'b1; redirect_pc = 64'h203;
    cycle();
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin
      tests_failed++; $display("FAIL rr_req: got req %b addr %h expected 1 200", imem_req, imem_addr);
    end
    tests_run++;
    if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_valid: got %b expected 0", if_valid); end
    dlv.delete();
    repeat (4) cycle();
    tests_run++;
    if (dlv.size() == 0 || dlv[0].pc !== 64'h200) begin
      tests_failed++; $display("FAIL rr_next_pc: got n=%0d pc %h expected 200", dlv.size(), dlv[0].pc);
    end
  endtask

  task automatic test_redirect_push_pop();
    int bad;
    do_reset();
    if_ready = 1'b0;
    repeat (5) cycle();
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 64'h0 || imem_rvalid !== 1'b1) begin
      tests_failed++; $display("FAIL rpp_setup: got valid %b pc %h expected 1 0", if_valid, if_pc);
    end
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h400;
    cycle();
    redirect_valid = 1'b0;
    tests_run++;
    if (if_valid !== 1'b0) begin tests_failed++; $display("FAIL rpp_cleared: got %b expected 0", if_valid); end
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h400) begin
      tests_failed++; $display("FAIL rpp_req: got req %b addr %h expected 1 400", imem_req, imem_addr);
    end
    dlv.delete();
    repeat (6) cycle();
    bad = 0;
    foreach (dlv[i]) if (dlv[i].pc < 64'h400) bad++;
    tests_run++;
    if (dlv.size() == 0 || dlv[0].pc !== 64'h400 || bad != 0) begin
      tests_failed++;
      $display("FAIL rpp_stale: got n=%0d first pc %h stale %0d expected first 400 stale 0",
               dlv.size(), dlv[0].pc, bad);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_ready = 1'b0;
    repeat (7) cycle();
    tests_run++;
    if (if_valid !== 1'b1 || imem_req !== 1'b0) begin
      tests_failed++; $display("FAIL rm_setup: got valid %b req %b expected 1 0", if_valid, imem_req);
    end
    reset = 1'b1;
    cycle();
    tests_run++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 64'h0) begin
      tests_failed++;
      $display("FAIL rm_state: got valid %b req %b addr %h expected 0 0 0", if_valid, imem_req, imem_addr);
    end
    reset = 1'b0;
    if_ready = 1'b1;
    #1;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      tests_failed++; $display("FAIL rm_first_req: got req %b addr %h expected 1 0", imem_req, imem_addr);
    end
    dlv.delete();
    repeat (4) cycle();
    tests_run++;
    if (dlv.size() == 0 || dlv[0].pc !== 64'h0) begin
      tests_failed++; $display("FAIL rm_restart: got n=%0d pc %h expected 0", dlv.size(), dlv[0].pc);
    end
  endtask

  task automatic test_wrap_and_run_redirect();
    do_reset();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle();
    redirect_valid = 1'b0;
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      tests_failed++; $display("FAIL wrap_start: got req %b addr %h expected 1 fffffffffffffffc", imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    cycle();
    cycle();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      tests_failed++; $display("FAIL wrap_next: got req %b addr %h expected 1 0", imem_req, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    cycle();
    redirect_valid = 1'b0;
    dlv.delete();
    tests_run++;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL run_gnt_drop: got %b expected 0", imem_req); end
    cycle();
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h40) begin
      tests_failed++; $display("FAIL drop_exit: got req %b addr %h expected 1 40", imem_req, imem_addr);
    end
    repeat (4) cycle();
    tests_run++;
    if (dlv.size() == 0 || dlv[0].pc !== 64'h40) begin
      tests_failed++; $display("FAIL drop_next_pc: got n=%0d pc %h expected 40", dlv.size(), dlv[0].pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_push_pop();
    test_reset_mid();
    test_wrap_and_run_redirect();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
